unified_mem_arbiter: RTL

Shares one unified, variable-latency memory port between the pipeline's instruction-fetch requester and data (LDR/STR) requester. Data accesses have priority, with a starvation guard so fetch always makes progress. A per-access timeout aborts hung accesses. The block sits between the pipelined core and the external memory, and produces fetch and memory stall indications for the hazard unit.

---
 rtl/arb_pkg.sv | 6 +
 rtl/arb_timeout_ctr.sv | 24 ++
 rtl/unified_mem_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  localparam int TMO_W = 8;
endpackage

// File: rtl/arb_timeout_ctr.sv
// Per-access wait counter; at_lim flags the last cycle an access may wait.
module arb_timeout_ctr
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic at_lim
);
  localparam logic [TMO_W-1:0] LIM = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && cnt != LIM) cnt <= cnt + 1'b1;
  end

  assign at_lim = (cnt == LIM);
endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and data requesters onto one variable-latency memory port,
// data first with a starvation guard for fetch, plus a per-access timeout.
module unified_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_LIM  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m,
  output logic              err,
  output logic              err_sticky
);
  localparam logic [3:0] SLIM = 4'(STARVE_LIM);

  arb_state_t        state;
  logic [3:0]        starve_cnt;
  logic              busy, tmo_lim, gnt;
  owner_t            gnt_own;
  logic [DATA_W-1:0] cap_data;

  assign busy     = (state == I_BUSY) || (state == D_BUSY);
  // Aborted accesses and writes both hand back zero.
  assign cap_data = (mem_ready && !mem_we) ? mem_rdata : '0;
  assign stall_f  = i_req & ~i_done;
  assign stall_m  = d_req & ~d_done;

  arb_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr    (!busy),
    .en     (busy && !mem_ready),
    .at_lim (tmo_lim)
  );

  // Data wins unless fetch has already watched STARVE_LIM data grants go by.
  always_comb begin
    gnt     = 1'b0;
    gnt_own = OWN_I;
    if (d_req && !(i_req && starve_cnt == SLIM)) begin
      gnt     = 1'b1;
      gnt_own = OWN_D;
    end else if (i_req) begin
      gnt     = 1'b1;
      gnt_own = OWN_I;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_done     <= 1'b0;
      i_rdata    <= '0;
      d_done     <= 1'b0;
      d_rdata    <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: if (gnt) begin
          mem_req <= 1'b1;
          if (gnt_own == OWN_D) begin
            state      <= D_BUSY;
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            starve_cnt <= !i_req ? '0 : (starve_cnt == SLIM) ? SLIM : starve_cnt + 4'd1;
          end else begin
            state      <= I_BUSY;
            mem_we     <= 1'b0;
            mem_addr   <= i_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end
        end
        I_BUSY, D_BUSY: if (mem_ready || tmo_lim) begin
          // mem_ready on the limit cycle completes normally.
          state      <= RESP;
          mem_req    <= 1'b0;
          err        <= !mem_ready;
          err_sticky <= err_sticky | !mem_ready;
          if (state == I_BUSY) begin
            i_done  <= 1'b1;
            i_rdata <= cap_data;
          end else begin
            d_done  <= 1'b1;
            d_rdata <= cap_data;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
